// File: rtl/rv_pipeline_pkg.sv
// Shared pipeline definitions: data width, canonical NOP and fetch FSM encoding.
package rv_pipeline_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0 -- what decode sees for a bubble or a flushed entry
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    FETCH   = 1'b0,
    DISCARD = 1'b1
  } fetch_state_e;

  // Instruction addresses are always word aligned; low two bits are dropped.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: PC, PC+4, instruction word and valid flag.
// Flush beats hold, hold beats load. A flush leaves the PC fields as they were.
module if_id_register
  import rv_pipeline_pkg::*;
(
  input  logic            CLK,
  input  logic            RESET,
  input  logic            load,
  input  logic            hold,
  input  logic            flush,
  input  logic [XLEN-1:0] next_pc,
  input  logic [XLEN-1:0] next_pc_plus_4,
  input  logic [XLEN-1:0] next_instruction,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc_plus_4,
  output logic [XLEN-1:0] if_id_instruction,
  output logic            if_id_valid
);

  // Register update with flush > hold > load priority; idle cycles keep contents.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      if_id_pc          <= '0;
      if_id_pc_plus_4   <= '0;
      if_id_instruction <= NOP_INSTR;
      if_id_valid       <= 1'b0;
    end else if (flush) begin
      if_id_instruction <= NOP_INSTR;
      if_id_valid       <= 1'b0;
    end else if (hold) begin
      if_id_valid       <= if_id_valid;
    end else if (load) begin
      if_id_pc          <= next_pc;
      if_id_pc_plus_4   <= next_pc_plus_4;
      if_id_instruction <= next_instruction;
      if_id_valid       <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, drives the instruction-memory read, applies EX
// redirects and hazard stalls, and feeds the IF/ID register.
module instruction_fetch_unit
  import rv_pipeline_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            STALL,
  input  logic            BRANCH_TAKEN,
  input  logic [XLEN-1:0] BRANCH_TARGET,
  output logic [XLEN-1:0] IMEM_ADDRESS,
  output logic            IMEM_READ,
  input  logic [XLEN-1:0] IMEM_READDATA,
  input  logic            IMEM_BUSYWAIT,
  output logic [XLEN-1:0] IF_ID_PC,
  output logic [XLEN-1:0] IF_ID_PC_PLUS_4,
  output logic [XLEN-1:0] IF_ID_INSTRUCTION,
  output logic            IF_ID_VALID
);

  fetch_state_e    state, state_next;
  logic [XLEN-1:0] pc, pc_next;
  logic [XLEN-1:0] redirect, redirect_next;
  logic [XLEN-1:0] pc_plus_4;
  logic [XLEN-1:0] target_aligned;
  logic            access_done;
  logic            ifid_load, ifid_hold, ifid_flush;

  // Memory port depends only on registered PC/state (and reset), never on EX or hazard inputs.
  assign IMEM_ADDRESS   = pc;
  assign IMEM_READ      = ~RESET;
  assign access_done    = IMEM_READ & ~IMEM_BUSYWAIT;
  assign pc_plus_4      = pc + XLEN'(4);
  assign target_aligned = word_align(BRANCH_TARGET);

  // PC, pending redirect and fetch state registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      redirect <= '0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      redirect <= redirect_next;
    end
  end

  // Next-state and IF/ID control: branch beats stall, stall beats a completed fetch.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    state_next    = state;
    pc_next       = pc;
    redirect_next = redirect;
    ifid_load     = 1'b0;
    ifid_hold     = 1'b0;
    ifid_flush    = 1'b0;
    case (state)
      FETCH: begin
        if (BRANCH_TAKEN) begin
          ifid_flush = 1'b1;
          if (access_done) begin
            pc_next = target_aligned;
          end else begin
            // Memory is mid-access: keep the address stable and park the target.
            redirect_next = target_aligned;
            state_next    = DISCARD;
          end
        end else if (STALL) begin
          ifid_hold = 1'b1;
        end else if (access_done) begin
          ifid_load = 1'b1;
          pc_next   = pc_plus_4;
        end else begin
          ifid_flush = 1'b1;
        end
      end
      DISCARD: begin
        // The stale access finishes here; its data never reaches IF/ID.
        ifid_flush = 1'b1;
        if (BRANCH_TAKEN) begin
          redirect_next = target_aligned;
        end
        if (access_done) begin
          pc_next    = BRANCH_TAKEN ? target_aligned : redirect;
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  if_id_register u_if_id (
    .CLK               (CLK),
    .RESET             (RESET),
    .load              (ifid_load),
    .hold              (ifid_hold),
    .flush             (ifid_flush),
    .next_pc           (pc),
    .next_pc_plus_4    (pc_plus_4),
    .next_instruction  (IMEM_READDATA),
    .if_id_pc          (IF_ID_PC),
    .if_id_pc_plus_4   (IF_ID_PC_PLUS_4),
    .if_id_instruction (IF_ID_INSTRUCTION),
    .if_id_valid       (IF_ID_VALID)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: a transaction-level fetch
// model is compared against the DUT every cycle, plus directed literal checks.
module tb_instruction_fetch_unit;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP         = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        STALL = 1'b0;
  logic        BRANCH_TAKEN = 1'b0;
  logic [31:0] BRANCH_TARGET = '0;
  logic        IMEM_BUSYWAIT = 1'b0;
  logic [31:0] IMEM_ADDRESS, IMEM_READDATA;
  logic        IMEM_READ;
  logic [31:0] IF_ID_PC, IF_ID_PC_PLUS_4, IF_ID_INSTRUCTION;
  logic        IF_ID_VALID;

  int tests = 0;
  int failures = 0;

  instruction_fetch_unit #(.RESET_PC(TB_RESET_PC)) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .STALL             (STALL),
    .BRANCH_TAKEN      (BRANCH_TAKEN),
    .BRANCH_TARGET     (BRANCH_TARGET),
    .IMEM_ADDRESS      (IMEM_ADDRESS),
    .IMEM_READ         (IMEM_READ),
    .IMEM_READDATA     (IMEM_READDATA),
    .IMEM_BUSYWAIT     (IMEM_BUSYWAIT),
    .IF_ID_PC          (IF_ID_PC),
    .IF_ID_PC_PLUS_4   (IF_ID_PC_PLUS_4),
    .IF_ID_INSTRUCTION (IF_ID_INSTRUCTION),
    .IF_ID_VALID       (IF_ID_VALID)
  );

  always #5 CLK = ~CLK;

  // Instruction memory contents: a fixed word at 0, an address-derived pattern elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr == 32'h0) ? 32'h0050_0093 : (addr ^ 32'h1357_9BDF);
  endfunction

  assign IMEM_READDATA = mem_word(IMEM_ADDRESS);

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
    end
  endtask

  // Reference model: the fetch PC, an optional pending redirect, and the IF/ID contents.
  logic [31:0] m_pc = TB_RESET_PC;
  bit          m_pending = 1'b0;
  logic [31:0] m_target = '0;
  logic [31:0] m_id_pc = '0, m_id_pc4 = '0, m_id_instr = NOP;
  bit          m_id_valid = 1'b0;

  always @(posedge CLK or posedge RESET) begin
    logic [31:0] tgt;
    bit          done;
    if (RESET) begin
      m_pc = TB_RESET_PC; m_pending = 1'b0; m_target = '0;
      m_id_pc = '0; m_id_pc4 = '0; m_id_instr = NOP; m_id_valid = 1'b0;
    end else begin
      tgt  = BRANCH_TARGET & 32'hFFFF_FFFC;
      done = !IMEM_BUSYWAIT;
      if (m_pending || BRANCH_TAKEN || (!STALL && !done)) begin
        // Bubble into IF/ID (stall is ignored while a redirect is outstanding).
        m_id_instr = NOP; m_id_valid = 1'b0;
        if (BRANCH_TAKEN) m_target = tgt;
        if ((m_pending || BRANCH_TAKEN) && done) begin
          m_pc = m_target; m_pending = 1'b0;
        end else if (BRANCH_TAKEN) begin
          m_pending = 1'b1;
        end
      end else if (!STALL) begin
        m_id_pc = m_pc; m_id_pc4 = m_pc + 32'd4; m_id_instr = mem_word(m_pc); m_id_valid = 1'b1;
        m_pc = m_pc + 32'd4;
      end
    end
  end

  // Per-cycle comparison on the falling edge, away from the active edge.
  always @(negedge CLK) begin
    check("imem_read", {31'b0, IMEM_READ}, {31'b0, !RESET});
    check("imem_address", IMEM_ADDRESS, m_pc);
    check("if_id_pc", IF_ID_PC, m_id_pc);
    check("if_id_pc_plus_4", IF_ID_PC_PLUS_4, m_id_pc4);
    check("if_id_instruction", IF_ID_INSTRUCTION, m_id_instr);
    check("if_id_valid", {31'b0, IF_ID_VALID}, {31'b0, m_id_valid});
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic drive(input bit stall, input bit br, input logic [31:0] tgt, input bit busy);
    STALL = stall; BRANCH_TAKEN = br; BRANCH_TARGET = tgt; IMEM_BUSYWAIT = busy;
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #2;
    check("rst_read", {31'b0, IMEM_READ}, 32'd0);
    check("rst_addr", IMEM_ADDRESS, 32'h0);
    check("rst_instr", IF_ID_INSTRUCTION, NOP);
    check("rst_valid", {31'b0, IF_ID_VALID}, 32'd0);
    RESET = 1'b0;

    // Zero-wait fetch from address 0
    tick();
    check("first_pc", IF_ID_PC, 32'h0);
    check("first_pc4", IF_ID_PC_PLUS_4, 32'h4);
    check("first_instr", IF_ID_INSTRUCTION, 32'h0050_0093);
    check("first_valid", {31'b0, IF_ID_VALID}, 32'd1);
    check("first_next_addr", IMEM_ADDRESS, 32'h4);
    tick();

    // Busywait for 3 cycles at PC=8
    drive(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("busy_addr", IMEM_ADDRESS, 32'h8);
      check("busy_bubble", IF_ID_INSTRUCTION, NOP);
    end
    drive(0, 0, 0, 0);
    tick();
    check("busy_done_pc", IF_ID_PC, 32'h8);
    check("busy_done_addr", IMEM_ADDRESS, 32'hC);
    tick();

    // Stall for 2 cycles at PC=0x10
    drive(1, 0, 0, 0);
    repeat (2) tick();
    check("stall_addr", IMEM_ADDRESS, 32'h10);
    check("stall_ifid_pc", IF_ID_PC, 32'hC);
    drive(0, 0, 0, 0);
    tick();
    check("stall_rel_pc", IF_ID_PC, 32'h10);
    check("stall_rel_addr", IMEM_ADDRESS, 32'h14);
    repeat (3) tick();

    // Branch with completed fetch at 0x20, unaligned target
    drive(0, 1, 32'h103, 0);
    tick();
    check("br_flush_valid", {31'b0, IF_ID_VALID}, 32'd0);
    check("br_flush_pc", IF_ID_PC, 32'h1C);
    check("br_addr", IMEM_ADDRESS, 32'h100);
    drive(0, 0, 0, 0);
    tick();
    check("br_tgt_pc", IF_ID_PC, 32'h100);
    drive(0, 1, 32'h30, 0);
    tick();

    // Branch during busywait at 0x30
    drive(0, 1, 32'h200, 1);
    tick();
    check("disc_addr0", IMEM_ADDRESS, 32'h30);
    drive(0, 0, 0, 1);
    tick();
    check("disc_addr1", IMEM_ADDRESS, 32'h30);
    drive(0, 0, 0, 0);
    tick();
    check("disc_dropped", {31'b0, IF_ID_VALID}, 32'd0);
    check("disc_redirect", IMEM_ADDRESS, 32'h200);
    tick();
    check("disc_tgt_pc", IF_ID_PC, 32'h200);

    // Branch beats stall
    drive(1, 1, 32'h300, 0);
    tick();
    check("br_over_stall", IMEM_ADDRESS, 32'h300);

    // Latest target wins in DISCARD
    drive(0, 1, 32'h400, 1);
    tick();
    drive(0, 1, 32'h500, 1);
    tick();
    drive(0, 0, 0, 0);
    tick();
    check("latest_target", IMEM_ADDRESS, 32'h500);
    tick();

    // Wrap at the top of the address space
    drive(0, 1, 32'hFFFF_FFFE, 0);
    tick();
    check("wrap_addr", IMEM_ADDRESS, 32'hFFFF_FFFC);
    drive(0, 0, 0, 0);
    tick();
    check("wrap_pc4", IF_ID_PC_PLUS_4, 32'h0);
    check("wrap_next", IMEM_ADDRESS, 32'h0);

    // Reset while in DISCARD drops the redirect
    drive(0, 1, 32'h800, 1);
    tick();
    drive(0, 0, 0, 1);
    #1 RESET = 1'b1;
    #1;
    check("mid_rst_addr", IMEM_ADDRESS, TB_RESET_PC);
    check("mid_rst_read", {31'b0, IMEM_READ}, 32'd0);
    check("mid_rst_valid", {31'b0, IF_ID_VALID}, 32'd0);
    tick();
    drive(0, 0, 0, 0);
    RESET = 1'b0;
    tick();
    check("post_rst_pc", IF_ID_PC, 32'h0);
    check("post_rst_addr", IMEM_ADDRESS, 32'h4);

    // Mixed traffic checked by the model each cycle
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(5) == 0, $urandom_range(7) == 0,
            $urandom & 32'h0000_0FFF, $urandom_range(3) == 0);
      tick();
    end
    drive(0, 0, 0, 0);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
